// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
// Module   : display_pkg
// Purpose  : BCD digit width, active-low 7-segment codes and the digit decoder
// Revision : 1.0
// ============================================================================
package display_pkg;

    localparam int BCD_W = 4;

    // Bit order {g,f,e,d,c,b,a}, a lit segment is 0
    localparam logic [6:0] SEG_0   = 7'h40;
    localparam logic [6:0] SEG_1   = 7'h79;
    localparam logic [6:0] SEG_2   = 7'h24;
    localparam logic [6:0] SEG_3   = 7'h30;
    localparam logic [6:0] SEG_4   = 7'h19;
    localparam logic [6:0] SEG_5   = 7'h12;
    localparam logic [6:0] SEG_6   = 7'h02;
    localparam logic [6:0] SEG_7   = 7'h78;
    localparam logic [6:0] SEG_8   = 7'h00;
    localparam logic [6:0] SEG_9   = 7'h10;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    function automatic logic [6:0] seg_decode(input logic [BCD_W-1:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_OFF;
        endcase
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit
// Purpose  : One BCD digit register with step-in and carry/borrow-out
// Revision : 1.0
// ============================================================================
module bcd_digit
    import display_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             step,
    input  logic             up,
    output logic [BCD_W-1:0] digit,
    output logic             carry
);

    logic [BCD_W-1:0] digit_q;
    logic [BCD_W-1:0] digit_d;

    always_comb begin
        digit_d = digit_q;
        if (clear) begin
            digit_d = '0;
        end else if (step) begin
            if (up) begin
                // >= so an out-of-range value recovers to zero instead of counting on
                digit_d = (digit_q >= 4'd9) ? 4'd0 : digit_q + 4'd1;
            end else begin
                digit_d = (digit_q == 4'd0) ? 4'd9 : digit_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit = digit_q;
    assign carry = step & (up ? (digit_q == 4'd9) : (digit_q == 4'd0));

endmodule
`default_nettype wire

// File: rtl/bcd_step_display.sv
`default_nettype none
// ============================================================================
// Module   : bcd_step_display
// Purpose  : Strobed up/down BCD counter with wrap flag and registered HEX drive
// Revision : 1.0
// ============================================================================
module bcd_step_display
    import display_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int BLANK_LZ = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  up,
    input  logic                  hold,
    input  logic                  clear,
    output logic [4*DIGITS-1:0]   count,
    output logic                  wrap,
    output logic [7*DIGITS-1:0]   hex
);

    function automatic logic [7*DIGITS-1:0] reset_hex();
        logic [7*DIGITS-1:0] r;
        for (int i = 0; i < DIGITS; i++) begin
            r[7*i +: 7] = (BLANK_LZ != 0 && i > 0) ? SEG_OFF : SEG_0;
        end
        return r;
    endfunction

    localparam logic [7*DIGITS-1:0] HEX_RST = reset_hex();

    logic                 step0;
    logic [DIGITS-1:0]    digit_step;
    logic [DIGITS-1:0]    carry;

    logic                 wrap_q;
    logic                 wrap_d;
    logic [7*DIGITS-1:0]  hex_q;
    logic [7*DIGITS-1:0]  hex_d;

    logic [BCD_W-1:0]     dig;
    logic [6:0]           seg;
    logic                 higher_nz;

    // clear and hold both suppress the strobe, so no carry ripples either
    assign step0 = enable & ~hold & ~clear;

    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_digit
            if (i == 0) begin : g_lsd
                assign digit_step[i] = step0;
            end else begin : g_chain
                assign digit_step[i] = carry[i-1];
            end

            bcd_digit u_digit (
                .clock (clock),
                .reset (reset),
                .clear (clear),
                .step  (digit_step[i]),
                .up    (up),
                .digit (count[BCD_W*i +: BCD_W]),
                .carry (carry[i])
            );
        end
    endgenerate

    // Carry out of the top digit means the whole counter rolled over
    assign wrap_d = carry[DIGITS-1];

    always_comb begin
        hex_d     = '0;
        dig       = '0;
        seg       = SEG_OFF;
        higher_nz = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            dig = count[BCD_W*i +: BCD_W];
            seg = seg_decode(dig);
            if (BLANK_LZ != 0 && i > 0 && !higher_nz && dig == '0) begin
                seg = SEG_OFF;
            end
            higher_nz = higher_nz | (dig != '0);
            hex_d[7*i +: 7] = seg;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wrap_q <= 1'b0;
            hex_q  <= HEX_RST;
        end else begin
            wrap_q <= wrap_d;
            hex_q  <= hex_d;
        end
    end

    assign wrap = wrap_q;
    assign hex  = hex_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_step_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_step_display
// Purpose  : Self-checking bench for bcd_step_display (plain and blanked views)
// Revision : 1.0
// ============================================================================
module tb_bcd_step_display;

    localparam int DIGITS = 4;
    localparam int MAXV   = 9999;
    localparam logic [6:0] SEG_TAB [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    logic clock = 1'b0;
    logic reset, enable, up, hold, clear;
    logic [4*DIGITS-1:0] count_a, count_b;
    logic                wrap_a, wrap_b;
    logic [7*DIGITS-1:0] hex_a, hex_b;

    always #10 clock = ~clock;

    bcd_step_display #(.DIGITS(DIGITS), .BLANK_LZ(0)) u_dut_a (
        .clock(clock), .reset(reset), .enable(enable), .up(up), .hold(hold),
        .clear(clear), .count(count_a), .wrap(wrap_a), .hex(hex_a)
    );

    bcd_step_display #(.DIGITS(DIGITS), .BLANK_LZ(1)) u_dut_b (
        .clock(clock), .reset(reset), .enable(enable), .up(up), .hold(hold),
        .clear(clear), .count(count_b), .wrap(wrap_b), .hex(hex_b)
    );

    int n_cmp = 0;
    int n_err = 0;
    int m_val;
    int m_prev;
    bit m_wrap;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
        logic [4*DIGITS-1:0] r;
        int p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [7*DIGITS-1:0] exp_hex(input int v, input bit blank);
        logic [7*DIGITS-1:0] r;
        logic [6:0] s;
        int p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            s = SEG_TAB[(v / p) % 10];
            if (blank && i > 0 && (v / p) == 0) s = 7'h7F;
            r[7*i +: 7] = s;
            p = p * 10;
        end
        return r;
    endfunction

    task automatic check_all(input string tag, input int cnt, input bit wr, input int hexval);
        check_eq({tag, "/count_a"}, 32'(count_a), 32'(to_bcd(cnt)));
        check_eq({tag, "/count_b"}, 32'(count_b), 32'(to_bcd(cnt)));
        check_eq({tag, "/wrap_a"},  32'(wrap_a),  32'(wr));
        check_eq({tag, "/wrap_b"},  32'(wrap_b),  32'(wr));
        check_eq({tag, "/hex_a"},   32'(hex_a),   32'(exp_hex(hexval, 1'b0)));
        check_eq({tag, "/hex_b"},   32'(hex_b),   32'(exp_hex(hexval, 1'b1)));
    endtask

    // One clock: apply inputs, advance the model on the edge, compare 1 ns later
    task automatic cycle(input string tag, input bit en, input bit u, input bit h, input bit c);
        enable = en; up = u; hold = h; clear = c;
        @(posedge clock);
        m_prev = m_val;
        m_wrap = 1'b0;
        if (c) begin
            m_val = 0;
        end else if (!h && en) begin
            if (u) begin
                m_wrap = (m_val == MAXV);
                m_val  = (m_val + 1) % (MAXV + 1);
            end else begin
                m_wrap = (m_val == 0);
                m_val  = (m_val + MAXV) % (MAXV + 1);
            end
        end
        #1;
        check_all(tag, m_val, m_wrap, m_prev);
    endtask

    task automatic ramp_up(input string tag, input int n);
        for (int k = 0; k < n; k++) cycle(tag, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; up = 1'b1; hold = 1'b0; clear = 1'b0;
        m_val = 0; m_prev = 0; m_wrap = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check_all("reset", 0, 1'b0, 0);

        // Twelve single strobes; an idle cycle then shows the hex lag
        for (int k = 0; k < 12; k++) begin
            cycle("up12", 1'b1, 1'b1, 1'b0, 1'b0);
            cycle("up12_gap", 1'b0, 1'b1, 1'b0, 1'b0);
        end
        check_eq("up12/value", 32'(count_a), 32'h0012);
        cycle("up12_idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // Both wrap directions, each followed by an idle cycle (wrap must drop)
        cycle("clr", 1'b0, 1'b0, 1'b0, 1'b1);
        cycle("wrap_dn", 1'b1, 1'b0, 1'b0, 1'b0);
        cycle("wrap_dn_after", 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("wrap_up", 1'b1, 1'b1, 1'b0, 1'b0);
        cycle("wrap_up_after", 1'b0, 1'b1, 1'b0, 1'b0);
        cycle("wrap_dn2", 1'b1, 1'b0, 1'b0, 1'b0);
        cycle("wrap_up2", 1'b1, 1'b1, 1'b0, 1'b0);

        // Borrow through three digits, then hold drops strobes
        cycle("clr", 1'b0, 1'b0, 1'b0, 1'b1);
        ramp_up("to1000", 1000);
        cycle("borrow", 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("borrow/value", 32'(count_a), 32'h0999);
        for (int k = 0; k < 3; k++) cycle("hold", 1'b1, 1'b1, 1'b1, 1'b0);
        cycle("hold_release", 1'b0, 1'b1, 1'b0, 1'b0);

        // Clear wins over a simultaneous strobe
        cycle("clr", 1'b0, 1'b0, 1'b0, 1'b1);
        ramp_up("to456", 456);
        cycle("clr_en", 1'b1, 1'b1, 1'b0, 1'b1);
        cycle("clr_then_up", 1'b1, 1'b1, 1'b0, 1'b0);
        cycle("clr_hold", 1'b1, 1'b1, 1'b1, 1'b1);

        // Asynchronous reset mid-cycle while the strobe is still high
        cycle("clr", 1'b0, 1'b0, 1'b0, 1'b1);
        ramp_up("to321", 321);
        #5;
        reset = 1'b0;
        m_val = 0;
        #1;
        check_all("async_rst", 0, 1'b0, 0);
        @(posedge clock);
        #1;
        check_all("in_rst", 0, 1'b0, 0);
        enable = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        cycle("post_rst_idle", 1'b0, 1'b1, 1'b0, 1'b0);
        cycle("post_rst_step", 1'b1, 1'b1, 1'b0, 1'b0);

        // Random mix of strobes, direction, hold and occasional clear
        for (int k = 0; k < 2000; k++) begin
            cycle("rand",
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2) != 0,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 63) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bcd_step_display.md
# bcd_step_display

Consumer of the single-cycle enable strobe produced by the system clock divider or a conditioned button. Holds a DIGITS-wide BCD counter that steps up or down once per accepted strobe, flags wrap-around, and drives one active-low 7-segment pattern per digit for the board's HEX displays. Sits between the tick source and the display pins.

## Interface
- DIGITS, 4, number of BCD digits and HEX displays (1–8)
- BLANK_LZ, 0, 1 = blank leading zero digits (digit 0 is never blanked)
- clock  input  1  50 MHz system clock
- reset  input  1  reset, asynchronous, active-low
- enable  input  1  step strobe, one cycle high per step
- up  input  1  direction: 1 = increment, 0 = decrement
- hold  input  1  1 = ignore enable, freeze count
- clear  input  1  synchronous clear of count to zero
- count  output  4*DIGITS  registered BCD value, digit 0 in [3:0]
- wrap  output  1  one-cycle pulse on wrap-around
- hex  output  7*DIGITS  segment patterns, digit i in [7i+6:7i], bit order {g,f,e,d,c,b,a}, active-low

## Operation
- Per-edge priority: clear > hold > enable > idle.
- clear: count ← 0, wrap ← 0, regardless of enable and hold.
- hold=1 (no clear): count unchanged; enable is dropped, not queued.
- Step up: digit 0 increments; a digit at 9 goes to 0 and carries into the next digit. All nines → all zeros, with wrap=1.
- Step down: digit 0 decrements; a digit at 0 goes to 9 and borrows from the next digit. All zeros → all nines, with wrap=1.
- wrap is high for exactly the cycle after the wrapping step. It is low otherwise, including on clear.
- Digits never hold values 10–15. The decoder maps 10–15 to all-off (7'h7F) as a defensive default.
- Segment codes, digits 0–9: 40,79,24,30,19,12,02,78,00,10 (hex).
- BLANK_LZ=1: digit i>0 outputs 7'h7F when it and every higher digit is zero. Example: 0007 shows only "7".
- enable held high for N cycles produces N steps. The block does no edge detection.

## Timing
- Reset values: count=0, wrap=0, hex = 7'h40 on every digit (also with BLANK_LZ=1: digit 0 shows "0", higher digits 7'h7F).
- count and wrap update on the clock edge that samples enable. Latency is 1 cycle from strobe to count.
- hex is registered from count. hex lags count by exactly 1 cycle, for 2 cycles total from strobe to pins.
- up is sampled on the same edge as enable. Changing up between strobes has no other effect.
- Asynchronous reset mid-operation clears all registers immediately. The first strobe after reset release steps from 0.

## Structure
- Shared package `display_pkg`:
  - segment constants SEG_0..SEG_9 and SEG_OFF
  - BCD digit width constant (4)
- Sub-module `bcd_digit`:
  - one 4-bit digit register with inc/dec, carry-in/borrow-in and carry-out/borrow-out
  - instantiated DIGITS times in a generate chain
- Segment decode is a function in `display_pkg`. It is not a separate module.
- The top level holds the step/clear/hold control, the wrap register, the blanking logic and the hex register.

## Test plan
- Reset, then release → count=0, wrap=0, hex=7'h40 per digit. Repeat with BLANK_LZ=1 → digit 0 = 7'h40, others 7'h7F.
- up=1, 12 single-cycle strobes from 0 → count=0x0012. Hex digit0=7'h24 and digit1=7'h79, one cycle after count.
- Preload to 9999 via 9999 up-steps (or down 1 from 0), then one up strobe → count=0x0000 and a single wrap pulse. One down strobe from 0 → count=0x9999 and a single wrap pulse.
- Borrow chain: count=0x1000, up=0, one strobe → 0x0999. hold=1 with 3 strobes → still 0x0999.
- clear and enable asserted in the same cycle with count=0x0456 → count=0, wrap=0. Next enable with up=1 → 0x0001.
- Assert reset asynchronously, mid-cycle, while enable is held high at count=0x0321 → count=0 and hex reset values immediately, with no step on the reset-release edge.
